// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access front end.
package spi_pkg;

  localparam int ADDR_W        = 7;
  localparam int REG_WIDTH_MAX = 32;
  localparam int SLAVE_W_MAX   = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  // Request as latched at acceptance; unused upper wdata/slave bits stay zero.
  typedef struct packed {
    logic                     rw;
    logic [ADDR_W-1:0]        addr;
    logic [REG_WIDTH_MAX-1:0] wdata;
    logic [SLAVE_W_MAX-1:0]   slave;
  } spi_req_t;

  // Frame length in bytes: one command byte plus the register payload.
  function automatic int nbytes(input int reg_width);
    return 1 + reg_width / 8;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream byte channel with producer/consumer views.
interface axis_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/spi_frame_ser.sv
// Serialises one register request into a command byte plus payload bytes,
// MSB first, with tlast on the final byte.
module spi_frame_ser
  import spi_pkg::*;
#(
  parameter int REG_WIDTH = 16,
  parameter int CNT_W     = 2
) (
  input  logic     clk_i,
  input  logic     arstn_i,
  input  logic     load_i,
  input  logic     abort_i,
  input  spi_req_t req_i,
  axis_if.master   m_axis
);

  localparam int NB = nbytes(REG_WIDTH);

  logic [REG_WIDTH-1:0] payload_reg;
  logic [CNT_W-1:0]     tx_cnt_reg;
  logic                 tvalid_reg;
  logic                 tlast_reg;
  logic [7:0]           tdata_reg;
  logic                 tx_hs;
  logic                 unused_req_bits;

  assign tx_hs = tvalid_reg && m_axis.tready;

  // Slave select and the payload bits above REG_WIDTH are consumed by the parent.
  assign unused_req_bits = ^{req_i.slave, req_i.wdata};

  // Byte sequencer: load presents byte 0 next cycle, each handshake advances.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      payload_reg <= '0;
      tx_cnt_reg  <= '0;
      tvalid_reg  <= 1'b0;
      tlast_reg   <= 1'b0;
      tdata_reg   <= 8'h00;
    end else if (abort_i) begin
      // Timeout abort: a pending unaccepted byte is withdrawn.
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
    end else if (load_i) begin
      tdata_reg   <= {req_i.rw, req_i.addr};
      payload_reg <= (req_i.rw == RW_READ) ? '0 : req_i.wdata[REG_WIDTH-1:0];
      tvalid_reg  <= 1'b1;
      tlast_reg   <= 1'b0;
      tx_cnt_reg  <= '0;
    end else if (tx_hs) begin
      tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
      if (tlast_reg) begin
        tvalid_reg <= 1'b0;
        tlast_reg  <= 1'b0;
      end else begin
        tdata_reg   <= payload_reg[REG_WIDTH-1 -: 8];
        payload_reg <= payload_reg << 8;
        tlast_reg   <= (tx_cnt_reg == CNT_W'(NB - 2));
      end
    end
  end

  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tlast  = tlast_reg;

endmodule

// File: rtl/spi_reg_access.sv
// Register transaction front end for an AXIS SPI master: frames the request,
// collects the returned MISO bytes and issues one response per request.
module spi_reg_access
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int REG_WIDTH  = 16,
  parameter int SLAVE_NUM  = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_rw_i,
  input  logic [6:0]                   req_addr_i,
  input  logic [REG_WIDTH-1:0]         req_wdata_i,
  input  logic [$clog2(SLAVE_NUM)-1:0] req_slave_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [REG_WIDTH-1:0]         resp_rdata_o,
  output logic                         resp_err_o,
  output logic [$clog2(SLAVE_NUM)-1:0] spi_addr_o,
  axis_if.master                       m_axis,
  axis_if.slave                        s_axis
);

  localparam int NB    = nbytes(REG_WIDTH);
  localparam int CNT_W = $clog2(NB + 1);
  localparam int TO_W  = $clog2(TIMEOUT);

  state_t                      state_reg;
  logic                        req_ready_reg;
  logic                        resp_valid_reg;
  logic                        resp_err_reg;
  logic [REG_WIDTH-1:0]        resp_rdata_reg;
  logic [REG_WIDTH-1:0]        rdata_reg;
  logic [$clog2(SLAVE_NUM)-1:0] spi_addr_reg;
  logic [CNT_W-1:0]            rx_cnt_reg;
  logic [TO_W-1:0]             to_cnt_reg;

  logic                              load;
  logic                              abort;
  logic                              m_hs;
  logic                              s_hs;
  logic [REG_WIDTH+DATA_WIDTH-1:0]   rx_shift;
  spi_req_t                          req_s;
  logic                              unused_tlast;

  assign m_hs     = m_axis.tvalid && m_axis.tready;
  assign s_hs     = s_axis.tvalid;
  assign load     = (state_reg == IDLE) && req_valid_i && req_ready_reg;
  assign abort    = (state_reg == XFER) && !m_hs && !s_hs &&
                    (to_cnt_reg == TO_W'(TIMEOUT - 1));
  assign rx_shift = {rdata_reg, s_axis.tdata};

  // The SPI master's end-of-frame marker carries no information here.
  assign unused_tlast = s_axis.tlast;

  assign req_s.rw    = req_rw_i;
  assign req_s.addr  = req_addr_i;
  assign req_s.wdata = REG_WIDTH_MAX'(req_wdata_i);
  assign req_s.slave = SLAVE_W_MAX'(req_slave_i);

  spi_frame_ser #(
    .REG_WIDTH (REG_WIDTH),
    .CNT_W     (CNT_W)
  ) u_ser (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .load_i  (load),
    .abort_i (abort),
    .req_i   (req_s),
    .m_axis  (m_axis)
  );

  // Transaction FSM: accept, run the frame with rx assembly and timeout, respond.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      rdata_reg      <= '0;
      spi_addr_reg   <= '0;
      rx_cnt_reg     <= '0;
      to_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            state_reg     <= XFER;
            req_ready_reg <= 1'b0;
            spi_addr_reg  <= req_slave_i;
            rx_cnt_reg    <= '0;
            to_cnt_reg    <= '0;
            rdata_reg     <= '0;
          end
        end
        XFER: begin
          if (m_hs || s_hs) begin
            to_cnt_reg <= '0;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
          if (s_hs) begin
            rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
            // Byte 0 arrives while the command byte is shifted out; drop it.
            if (rx_cnt_reg != '0) begin
              rdata_reg <= rx_shift[REG_WIDTH-1:0];
            end
            if (rx_cnt_reg == CNT_W'(NB - 1)) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b0;
              resp_rdata_reg <= rx_shift[REG_WIDTH-1:0];
            end
          end else if (abort) begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b1;
            resp_rdata_reg <= rdata_reg;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_reg;
  assign resp_valid_o  = resp_valid_reg;
  assign resp_err_o    = resp_err_reg;
  assign resp_rdata_o  = resp_rdata_reg;
  assign spi_addr_o    = spi_addr_reg;
  assign s_axis.tready = 1'b1;

endmodule

// File: tb/tb_spi_reg_access.sv
// Scoreboard bench for spi_reg_access with a byte-echo SPI master model.
module tb_spi_reg_access;
  import spi_pkg::*;

  localparam int REG_WIDTH = 16;
  localparam int SLAVE_NUM = 2;
  localparam int TIMEOUT   = 64;
  localparam int NB        = 3;

  typedef struct packed { logic [7:0] data; logic last; } tx_exp_t;
  typedef struct packed { logic [15:0] rdata; logic err; } resp_exp_t;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_rw_i = 1'b0;
  logic [6:0]  req_addr_i = '0;
  logic [15:0] req_wdata_i = '0;
  logic [0:0]  req_slave_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [15:0] resp_rdata_o;
  logic        resp_err_o;
  logic [0:0]  spi_addr_o;

  axis_if #(.DATA_WIDTH(8)) m_axis_if ();
  axis_if #(.DATA_WIDTH(8)) s_axis_if ();

  always #5 clk_i = ~clk_i;

  spi_reg_access #(
    .DATA_WIDTH (8),
    .REG_WIDTH  (REG_WIDTH),
    .SLAVE_NUM  (SLAVE_NUM),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_rw_i     (req_rw_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_slave_i  (req_slave_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .spi_addr_o   (spi_addr_o),
    .m_axis       (m_axis_if),
    .s_axis       (s_axis_if)
  );

  tx_exp_t    exp_tx_q[$];
  resp_exp_t  exp_resp_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] pend_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int tx_idx = 0;
  int rx_idx = 0;
  int stall_cnt = 0;
  int resp_hold = 0;
  int resp_done = 0;
  bit stall_pending = 0;
  bit resp_hold_pending = 0;
  bit chk_tvalid_next = 0;
  bit chk_resp_next = 0;
  bit hold_valid = 0;
  bit resp_hold_valid = 0;
  bit last_req_hs = 0;
  logic [7:0]  hold_d;
  logic        hold_l;
  logic [15:0] resp_hold_d;
  logic [0:0]  cur_slave = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset();
    check_eq("rst_req_ready", req_ready_o, 1);
    check_eq("rst_resp_valid", resp_valid_o, 0);
    check_eq("rst_resp_rdata", resp_rdata_o, 0);
    check_eq("rst_resp_err", resp_err_o, 0);
    check_eq("rst_spi_addr", spi_addr_o, 0);
    check_eq("rst_m_tvalid", m_axis_if.tvalid, 0);
    check_eq("rst_m_tlast", m_axis_if.tlast, 0);
    check_eq("rst_m_tdata", m_axis_if.tdata, 0);
    check_eq("rst_s_tready", s_axis_if.tready, 1);
  endtask

  // One clock of the bus model; runs at the falling edge.
  task automatic cycle();
    bit m_hs, s_hs, r_hs, q_hs;
    tx_exp_t   te;
    resp_exp_t re;
    if (stall_pending && m_axis_if.tvalid && tx_idx == 1) begin
      stall_cnt = 5;
      stall_pending = 0;
    end
    m_axis_if.tready = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    if (resp_hold_pending && resp_valid_o) begin
      resp_hold = 10;
      resp_hold_pending = 0;
    end
    resp_ready_i = (resp_hold == 0);
    if (resp_hold > 0) resp_hold--;
    s_axis_if.tvalid = (pend_q.size() > 0);
    s_axis_if.tdata  = (pend_q.size() > 0) ? pend_q[0] : 8'h00;

    if (chk_tvalid_next) begin
      check_eq("tx_latency", m_axis_if.tvalid, 1);
      check_eq("spi_addr_accept", spi_addr_o, cur_slave);
      chk_tvalid_next = 0;
    end
    if (chk_resp_next) begin
      check_eq("resp_latency", resp_valid_o, 1);
      chk_resp_next = 0;
    end
    if (hold_valid) begin
      check_eq("stall_tdata", m_axis_if.tdata, hold_d);
      check_eq("stall_tlast", m_axis_if.tlast, hold_l);
    end
    if (resp_hold_valid) check_eq("resp_hold_rdata", resp_rdata_o, resp_hold_d);
    if (resp_valid_o) check_eq("req_blocked", req_ready_o, 0);

    m_hs = m_axis_if.tvalid && m_axis_if.tready;
    s_hs = s_axis_if.tvalid && s_axis_if.tready;
    r_hs = resp_valid_o && resp_ready_i;
    q_hs = req_valid_i && req_ready_o;

    if (s_hs) begin
      void'(pend_q.pop_front());
      rx_idx++;
      if (rx_idx == NB) chk_resp_next = 1;
    end
    if (m_hs) begin
      if (exp_tx_q.size() == 0) begin
        check_eq("tx_unexpected", exp_tx_q.size(), 1);
      end else begin
        te = exp_tx_q.pop_front();
        check_eq("tx_tdata", m_axis_if.tdata, te.data);
        check_eq("tx_tlast", m_axis_if.tlast, te.last);
        check_eq("spi_addr_stable", spi_addr_o, cur_slave);
      end
      tx_idx++;
      if (miso_q.size() > 0) pend_q.push_back(miso_q.pop_front());
    end
    if (r_hs) begin
      if (exp_resp_q.size() == 0) begin
        check_eq("resp_unexpected", exp_resp_q.size(), 1);
      end else begin
        re = exp_resp_q.pop_front();
        check_eq("resp_rdata", resp_rdata_o, re.rdata);
        check_eq("resp_err", resp_err_o, re.err);
      end
      resp_done++;
    end
    hold_valid      = m_axis_if.tvalid && !m_axis_if.tready;
    hold_d          = m_axis_if.tdata;
    hold_l          = m_axis_if.tlast;
    resp_hold_valid = resp_valid_o && !resp_ready_i;
    resp_hold_d     = resp_rdata_o;
    last_req_hs     = q_hs;
    if (q_hs) begin
      tx_idx = 0;
      rx_idx = 0;
      chk_tvalid_next = 1;
      cur_slave = req_slave_i;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send_req(input logic rw, input logic [6:0] addr, input logic [15:0] wdata,
                          input logic [0:0] slave, input logic [7:0] m0, input logic [7:0] m1,
                          input logic [7:0] m2, input int n_miso,
                          input logic [15:0] exp_rdata, input logic exp_err);
    exp_tx_q.push_back('{data: {rw, addr}, last: 1'b0});
    exp_tx_q.push_back('{data: rw ? 8'h00 : wdata[15:8], last: 1'b0});
    exp_tx_q.push_back('{data: rw ? 8'h00 : wdata[7:0], last: 1'b1});
    exp_resp_q.push_back('{rdata: exp_rdata, err: exp_err});
    miso_q.push_back(m0);
    if (n_miso > 1) miso_q.push_back(m1);
    if (n_miso > 2) miso_q.push_back(m2);
    req_rw_i    = rw;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_slave_i = slave;
    req_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (last_req_hs) break;
    end
    check_eq("req_accept", last_req_hs, 1);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < TIMEOUT + 200; i++) begin
      if (resp_done >= target) break;
      cycle();
    end
    check_eq("resp_count", resp_done, target);
  endtask

  initial begin
    m_axis_if.tready = 1'b1;
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tdata  = 8'h00;
    s_axis_if.tlast  = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset();
    arstn_i = 1'b1;
    cycle();
    cycle();

    // Write 0x15 <- 0xBEEF on slave 1
    send_req(1'b0, 7'h15, 16'hBEEF, 1'b1, 8'h00, 8'h11, 8'h22, 3, 16'h1122, 1'b0);
    wait_resp(1);
    $display("txn 1: write 0x15 done, responses=%0d", resp_done);

    // Read 0x2A on slave 0
    send_req(1'b1, 7'h2A, 16'h0000, 1'b0, 8'hFF, 8'h12, 8'h34, 3, 16'h1234, 1'b0);
    wait_resp(2);
    $display("txn 2: read 0x2A done, responses=%0d", resp_done);

    // Downstream back-pressure on byte 1
    stall_pending = 1;
    send_req(1'b0, 7'h33, 16'hBEEF, 1'b1, 8'h01, 8'h02, 8'h03, 3, 16'h0203, 1'b0);
    wait_resp(3);
    check_eq("stall_applied", stall_pending, 0);
    $display("txn 3: stalled write done, responses=%0d", resp_done);

    // Response held by the requester; next request queued behind it
    resp_hold_pending = 1;
    send_req(1'b0, 7'h01, 16'hA5C3, 1'b0, 8'h00, 8'h5A, 8'h3C, 3, 16'h5A3C, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (resp_valid_o) break;
      cycle();
    end
    check_eq("resp_seen", resp_valid_o, 1);
    $display("txn 4: held response presented, responses=%0d", resp_done);

    // Only two MISO bytes come back: timeout abort
    send_req(1'b1, 7'h7F, 16'h0000, 1'b1, 8'hAB, 8'hCD, 8'h00, 2, 16'h00CD, 1'b1);
    check_eq("accept_after_resp", resp_done, 4);
    wait_resp(5);
    check_eq("idle_after_to", req_ready_o, 1);
    check_eq("tvalid_after_to", m_axis_if.tvalid, 0);
    $display("txn 5: timeout response done, responses=%0d", resp_done);

    send_req(1'b0, 7'h00, 16'h0102, 1'b0, 8'h09, 8'h08, 8'h07, 3, 16'h0807, 1'b0);
    wait_resp(6);
    $display("txn 6: write after timeout done, responses=%0d", resp_done);

    // Reset after byte 0 of a read
    send_req(1'b1, 7'h05, 16'h0000, 1'b1, 8'h00, 8'h77, 8'h66, 3, 16'h7766, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (tx_idx >= 1) break;
      cycle();
    end
    arstn_i = 1'b0;
    #1;
    check_reset();
    exp_tx_q.delete();
    exp_resp_q.delete();
    miso_q.delete();
    pend_q.delete();
    hold_valid = 0;
    resp_hold_valid = 0;
    chk_resp_next = 0;
    chk_tvalid_next = 0;
    m_axis_if.tready = 1'b1;
    s_axis_if.tvalid = 1'b0;
    @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (20) cycle();
    check_eq("no_resp_after_rst", resp_done, 6);
    $display("txn 7: read aborted by reset, responses=%0d", resp_done);

    send_req(1'b1, 7'h10, 16'h0000, 1'b1, 8'h00, 8'hDE, 8'hAD, 3, 16'hDEAD, 1'b0);
    wait_resp(7);
    $display("txn 8: read after reset done, responses=%0d", resp_done);

    check_eq("tx_left", exp_tx_q.size(), 0);
    check_eq("resp_left", exp_resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
